// File: rtl/l0mdt_buses_constants.sv
// Shared MTC bus constants and word type for the L0 MDT trigger path.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package l0mdt_buses_constants;

  // Width of one MTC-to-SL word; the top bit flags a valid word.
  localparam int MTC2SL_LEN = 32;
  localparam int MTC_VALID_BIT = MTC2SL_LEN - 1;

  typedef logic [MTC2SL_LEN-1:0] mtc_word_t;

endpackage

// File: rtl/mtc_lane_fifo.sv
// Per-lane word buffer with show-ahead head, synchronous write/read, async reset.
// Latency: a word written at edge k is visible on dout (empty=0) after edge k.
// Backpressure: writes while full and reads while empty are ignored; caller gates them.
module mtc_lane_fifo
  import l0mdt_buses_constants::*;
#(
  parameter int WIDTH = MTC2SL_LEN,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_wr;
  logic             w_do_rd;

  // One extra pointer bit tells a wrapped (full) FIFO apart from an empty one.
  assign full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign empty   = (r_wr_ptr == r_rd_ptr);
  assign count   = r_wr_ptr - r_rd_ptr;
  assign dout    = r_mem[r_rd_ptr[AW-1:0]];
  assign w_do_wr = wr_en && !full;
  assign w_do_rd = rd_en && !empty;

  // Storage array: data only, no reset needed since pointers define validity.
  always_ff @(posedge clock) begin
    if (w_do_wr) begin
      r_mem[r_wr_ptr[AW-1:0]] <= din;
    end
  end

  // Pointer advance on accepted write/read; reset discards all contents.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/mtc_output_serializer.sv
// Buffers n parallel MTC lanes and serialises them round-robin onto one valid/ready stream.
// Latency: 2 cycles minimum from input sample to mtc_o (FIFO write, then output register load).
// Backpressure: output holds while valid & !ready; lane FIFOs absorb, words to a full FIFO are dropped and counted.
module mtc_output_serializer
  import l0mdt_buses_constants::*;
#(
  parameter int MTC2SL_LEN    = l0mdt_buses_constants::MTC2SL_LEN,
  parameter int n_PRIMARY_MTC = 3,
  parameter int FIFO_DEPTH    = 8,
  parameter int DROP_CNT_W    = 8,
  localparam int LANE_W = (n_PRIMARY_MTC > 1) ? $clog2(n_PRIMARY_MTC) : 1
) (
  input  logic                                clock,
  input  logic                                rst,
  input  logic [MTC2SL_LEN*n_PRIMARY_MTC-1:0] mtc,
  output logic [MTC2SL_LEN-1:0]               mtc_o,
  output logic                                mtc_valid_o,
  input  logic                                mtc_ready_i,
  output logic [LANE_W-1:0]                   mtc_lane_o,
  output logic [n_PRIMARY_MTC-1:0]            overflow_o,
  output logic [DROP_CNT_W*n_PRIMARY_MTC-1:0] drop_cnt_o
);

  localparam int VLD   = MTC2SL_LEN - 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [MTC2SL_LEN-1:0] VLD_MASK = MTC2SL_LEN'(1) << VLD;

  logic [MTC2SL_LEN-1:0] w_lane_dat  [n_PRIMARY_MTC];
  logic [MTC2SL_LEN-1:0] w_fifo_dout [n_PRIMARY_MTC];
  logic [CNT_W-1:0]      w_fifo_cnt  [n_PRIMARY_MTC];
  logic [n_PRIMARY_MTC-1:0] w_in_vld;
  logic [n_PRIMARY_MTC-1:0] w_wr_en;
  logic [n_PRIMARY_MTC-1:0] w_rd_en;
  logic [n_PRIMARY_MTC-1:0] w_drop;
  logic [n_PRIMARY_MTC-1:0] w_fifo_full;
  logic [n_PRIMARY_MTC-1:0] w_fifo_empty;

  logic                  w_load;
  logic                  w_gnt_vld;
  logic [LANE_W-1:0]     w_gnt_idx;
  logic [LANE_W-1:0]     w_rr_nxt;
  int                    w_scan_idx;

  logic [LANE_W-1:0]     r_rr_ptr;
  logic                  r_vld;
  logic [MTC2SL_LEN-1:0] r_dat;
  logic [LANE_W-1:0]     r_lane;
  logic [n_PRIMARY_MTC-1:0] r_ovf;
  logic [DROP_CNT_W-1:0] r_drop_cnt [n_PRIMARY_MTC];

  // Output register may take a new word when empty or when the current one is accepted.
  assign w_load = !r_vld || mtc_ready_i;

  for (genvar g = 0; g < n_PRIMARY_MTC; g++) begin : g_lane
    assign w_lane_dat[g] = mtc[g*MTC2SL_LEN +: MTC2SL_LEN];
    assign w_in_vld[g]   = w_lane_dat[g][VLD];
    // Fullness is the pre-edge state, so a same-edge pop does not make room.
    assign w_wr_en[g]    = w_in_vld[g] && !w_fifo_full[g];
    assign w_drop[g]     = w_in_vld[g] && w_fifo_full[g];
    assign w_rd_en[g]    = w_load && w_gnt_vld && (w_gnt_idx == LANE_W'(g));
    assign drop_cnt_o[g*DROP_CNT_W +: DROP_CNT_W] = r_drop_cnt[g];

    mtc_lane_fifo #(
      .WIDTH (MTC2SL_LEN),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clock (clock),
      .rst   (rst),
      .wr_en (w_wr_en[g]),
      .din   (w_lane_dat[g]),
      .full  (w_fifo_full[g]),
      .rd_en (w_rd_en[g]),
      .dout  (w_fifo_dout[g]),
      .empty (w_fifo_empty[g]),
      .count (w_fifo_cnt[g])
    );

    // Full flag and occupancy count must always tell the same story.
    a_full_cnt : assert property (@(posedge clock) disable iff (rst)
      w_fifo_full[g] == (w_fifo_cnt[g] == CNT_W'(FIFO_DEPTH)));
  end

  // Cyclic search from rr_ptr; scanning backwards lets the nearest non-empty lane win.
  always_comb begin
    w_gnt_vld  = 1'b0;
    w_gnt_idx  = '0;
    w_scan_idx = 0;
    for (int k = n_PRIMARY_MTC - 1; k >= 0; k--) begin
      w_scan_idx = int'(r_rr_ptr) + k;
      if (w_scan_idx >= n_PRIMARY_MTC) w_scan_idx = w_scan_idx - n_PRIMARY_MTC;
      if (!w_fifo_empty[w_scan_idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = LANE_W'(w_scan_idx);
      end
    end
  end

  assign w_rr_nxt = (w_gnt_idx == LANE_W'(n_PRIMARY_MTC - 1)) ? '0 : w_gnt_idx + 1'b1;

  // Output register and round-robin pointer; both only move on a load-enabled edge.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_vld    <= 1'b0;
      r_dat    <= '0;
      r_lane   <= '0;
      r_rr_ptr <= '0;
    end else if (w_load) begin
      if (w_gnt_vld) begin
        r_vld    <= 1'b1;
        r_dat    <= w_fifo_dout[w_gnt_idx] | VLD_MASK;
        r_lane   <= w_gnt_idx;
        r_rr_ptr <= w_rr_nxt;
      end else begin
        r_vld <= 1'b0;
      end
    end
  end

  // Sticky overflow flags and saturating per-lane drop counters.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_ovf <= '0;
      for (int i = 0; i < n_PRIMARY_MTC; i++) r_drop_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < n_PRIMARY_MTC; i++) begin
        if (w_drop[i]) begin
          r_ovf[i] <= 1'b1;
          if (r_drop_cnt[i] != '1) r_drop_cnt[i] <= r_drop_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign mtc_o       = r_dat;
  assign mtc_valid_o = r_vld;
  assign mtc_lane_o  = r_lane;
  assign overflow_o  = r_ovf;

endmodule
